uart_rx_byte: RTL and testbench
===============================

# uart_rx_byte

Serial UART receiver feeding the command decoder that turns keyboard ASCII into movement/scanner/reset pulses. It oversamples the asynchronous `I_rx` line and reassembles 8N1 frames (optionally 8E1) into bytes. It presents each byte with a one-cycle valid strobe, which is exactly the `I_write_data` / `I_read_data_valid` pair the decoder consumes. Malformed frames are flagged and never strobed as valid.

## Interface
- `CLK_FREQ_HZ`, default 100_000_000: frequency of `I_sys_clk`.
- `BAUD_RATE`, default 115200: serial bit rate.
- `OVERSAMPLE`, default 16: ticks per bit; must be ≥ 8 and even.
- `I_sys_clk`  in  1  system clock; single clock domain.
- `I_rst`  in  1  reset, synchronous and active-high.
- `I_rx`  in  1  asynchronous serial line, idle high.
- `o_read_data`  out  8  last received byte, LSB first on the wire.
- `o_read_data_valid`  out  1  one-cycle strobe when `o_read_data` is new.
- `o_frame_error`  out  1  one-cycle strobe: stop bit sampled low.
- `o_parity_error`  out  1  one-cycle strobe: parity mismatch. Constant 0 without the parity macro.

## Operation
- **Input synchroniser:** `I_rx` passes through 2 flops. Both flops reset to 1.
- **Tick divider:** DIV = CLK_FREQ_HZ / (BAUD_RATE × OVERSAMPLE), integer truncation; 54 with the defaults.
  - The divider emits a one-cycle tick every DIV clocks.
  - It free-runs; it is not restarted on a start bit.
- **State machine:** states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. Reset state is IDLE.
- **Bit sampling:** each bit value is the majority of the synced line at ticks OVERSAMPLE/2−1, /2 and /2+1 within the bit.
- **IDLE → START:** on a synced line low.
- **START:** if the mid-bit majority is 1, return to IDLE (glitch rejection, no strobe). Otherwise, at bit end go to DATA.
- **DATA:** shift 8 bits LSB first; a 3-bit counter runs 0..7. After bit 7, go to PARITY if enabled, else STOP.
- **PARITY:** even parity over the 8 data bits plus the received parity bit. Record a mismatch; do not abort the frame.
- **STOP, mid-bit majority = 1:**
  - If a parity mismatch was recorded: pulse `o_parity_error`, no valid strobe.
  - Otherwise: load `o_read_data` and pulse `o_read_data_valid`.
  - Then go to IDLE. The remaining half stop bit is not waited out, so back-to-back frames are accepted.
- **STOP, majority = 0:**
  - Pulse `o_frame_error` only; no valid strobe and no parity strobe.
  - Go to WAIT_HIGH.
- **WAIT_HIGH:** stay until the synced line reads 1, then go to IDLE. A held-low line (break) yields exactly one frame error.
- **Data hold:** `o_read_data` holds its value until the next valid frame. It does not change on error frames.
- **Reset values:** `o_read_data` = 8'h00; `o_read_data_valid`, `o_frame_error`, `o_parity_error` = 0; state IDLE; shift register, counters and divider all cleared.

## Timing
- **Strobe width:** every strobe is high for exactly one `I_sys_clk` cycle. At most one strobe fires per frame.
- **Latency:** the strobe is registered and asserts in the cycle after the stop-bit centre-sample tick.
  - Roughly 9.5 bit-times after the start edge, plus 2 synchroniser cycles.
  - 10.5 bit-times with parity.
- **Start detection:** start-edge detection jitter is ≤ 1 tick (DIV clocks).
- **Data validity:** `o_read_data` is valid in the same cycle as `o_read_data_valid` and after it.
- **Reset mid-frame:** `I_rst` high for one clock aborts any frame. Outputs follow the reset values on the next edge; no strobe for the aborted frame.
- **No flow control:** the downstream decoder must accept one byte per frame time. A byte is never held pending.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state exists and frames are 11 bits, 8E1.
  - `o_parity_error` is live.
- Not defined:
  - PARITY is compiled out; frames are 10 bits, 8N1.
  - `o_parity_error` is tied to 0 and the port remains for a stable interface.

## Structure
- **Shared package `uart_pkg`:**
  - State encoding localparams.
  - The command ASCII codes: a=8'h61, w=8'h77, s=8'h73, d=8'h64, b=8'h62, n=8'h6E, m=8'h6D. These are shared with the command decoder.
  - A function computing DIV from CLK_FREQ_HZ, BAUD_RATE and OVERSAMPLE.
- **Sub-module `uart_baud_tick`:** the divider counter with parameter DIV and a one-cycle tick output.

## Test plan
- **Single byte:** send 8'h61 ('a') 8N1 at 115200 baud, 100 MHz clock → one valid strobe with `o_read_data` = 8'h61, both error outputs 0.
- **Back-to-back bytes:** 8'h77, 8'h73, 8'h6D with no idle gap → three strobes in order; data 77, 73, 6D.
- **Glitch rejection:** a 3-tick low pulse on an idle line → no strobes; the next valid frame 8'h64 is still received correctly.
- **Framing error:** 8'h62 with the stop bit forced low → one `o_frame_error` strobe, no valid strobe, `o_read_data` unchanged. Line held low 5 bit-times, then 8'h6E → exactly one error, then valid 6E.
- **Reset mid-frame:** assert `I_rst` one cycle during bit 4 of 8'h61 → no strobe, outputs at reset values. The next 8'h61 frame is received correctly.
- **Parity (`UART_RX_PARITY_EN` only):**
  - 8'h61 with parity bit 1 (the correct value for even parity) → valid strobe, data 61.
  - Same byte with parity bit 0 → `o_parity_error` strobe only.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, command ASCII codes
// used by the downstream decoder, and the tick-divider/majority helpers.
package uart_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = S_IDLE,
    START     = S_START,
    DATA      = S_DATA,
    PARITY    = S_PARITY,
    STOP      = S_STOP,
    WAIT_HIGH = S_WAIT_HIGH
  } rx_state_e;

  localparam logic [7:0] CMD_A = 8'h61;
  localparam logic [7:0] CMD_W = 8'h77;
  localparam logic [7:0] CMD_S = 8'h73;
  localparam logic [7:0] CMD_D = 8'h64;
  localparam logic [7:0] CMD_B = 8'h62;
  localparam logic [7:0] CMD_N = 8'h6E;
  localparam logic [7:0] CMD_M = 8'h6D;

  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    return clk_hz / (baud * os);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle tick every DIV clocks.
module uart_baud_tick #(
  parameter int unsigned DIV = 54
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'((DIV > 0) ? DIV - 1 : 0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q == LAST);
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx_byte.sv
// Oversampling UART receiver: reassembles 8N1 frames into bytes with one-cycle
// valid/error strobes. Define UART_RX_PARITY_EN for 8E1 frames and a live o_parity_error.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input  logic       I_sys_clk,
  input  logic       I_rst,
  input  logic       I_rx,
  output logic [7:0] o_read_data,
  output logic       o_read_data_valid,
  output logic       o_frame_error,
  output logic       o_parity_error
);
  localparam int unsigned DIV = calc_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned TW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_S2  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

  logic          rx_meta_q, rx_sync_q, tick_s;
  rx_state_e     state_q, state_d, after_data_s;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d, data_q, data_d;
  logic [1:0]    smp_q, smp_d;
  logic          valid_q, valid_d, ferr_q, ferr_d;
  logic          maj_s, mid_s, end_s, busy_s;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d, perr_q, perr_d;
  assign after_data_s = PARITY;
`else
  assign after_data_s = STOP;
`endif

  uart_baud_tick #(.DIV((DIV > 0) ? DIV : 1)) u_tick (
    .clk_i  (I_sys_clk),
    .rst_i  (I_rst),
    .tick_o (tick_s)
  );

  // Majority is resolved on the third centre tick, using the two stored samples.
  assign maj_s  = maj3(smp_q[0], smp_q[1], rx_sync_q);
  assign mid_s  = tick_s && (tcnt_q == T_S2);
  assign end_s  = tick_s && (tcnt_q == T_END);
  assign busy_s = (state_q == START) || (state_q == DATA) ||
                  (state_q == PARITY) || (state_q == STOP);

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    smp_d   = smp_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    if (!busy_s) begin
      tcnt_d = '0;
    end else if (tick_s) begin
      tcnt_d = (tcnt_q == T_END) ? '0 : tcnt_q + TW'(1);
    end else begin
      tcnt_d = tcnt_q;
    end
    if (busy_s && tick_s && (tcnt_q == T_S0)) begin
      smp_d[0] = rx_sync_q;
    end else if (busy_s && tick_s && (tcnt_q == T_S1)) begin
      smp_d[1] = rx_sync_q;
    end else begin
      smp_d = smp_q;
    end

    case (state_q)
      IDLE: begin
        bcnt_d = 3'd0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        state_d = rx_sync_q ? IDLE : START;
      end
      START: begin
        if (mid_s && maj_s) state_d = IDLE;
        else if (end_s)     state_d = DATA;
        else                state_d = START;
      end
      DATA: begin
        if (mid_s) shift_d = {maj_s, shift_q[7:1]};
        else       shift_d = shift_q;
        if (end_s) begin
          bcnt_d  = bcnt_q + 3'd1;
          state_d = (bcnt_q == 3'd7) ? after_data_s : DATA;
        end else begin
          state_d = DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (mid_s) par_bad_d = ^{shift_q, maj_s};
        else       par_bad_d = par_bad_q;
        state_d = end_s ? STOP : PARITY;
      end
`endif
      STOP: begin
        if (mid_s && maj_s) begin
`ifdef UART_RX_PARITY_EN
          if (par_bad_q) begin
            perr_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end
`else
          valid_d = 1'b1;
          data_d  = shift_q;
`endif
          state_d = IDLE;
        end else if (mid_s) begin
          ferr_d  = 1'b1;
          state_d = WAIT_HIGH;
        end else begin
          state_d = STOP;
        end
      end
      WAIT_HIGH: state_d = rx_sync_q ? IDLE : WAIT_HIGH;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= IDLE;
      tcnt_q    <= '0;
      bcnt_q    <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      smp_q     <= 2'b00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= I_rx;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      smp_q     <= smp_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
    end
  end
  assign o_parity_error = perr_q;
`else
  assign o_parity_error = 1'b0;
`endif

  assign o_read_data       = data_q;
  assign o_read_data_valid = valid_q;
  assign o_frame_error     = ferr_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte at 100 MHz / 115200 baud / x16 (864 clocks per bit).
module tb_uart_rx_byte;
  localparam int BIT_CLKS  = 864;
  localparam int TICK_CLKS = 54;

  typedef struct packed {
    logic [2:0] flags;
    logic [7:0] data;
  } exp_t;

  localparam logic [2:0] F_VALID = 3'b100;
  localparam logic [2:0] F_FERR  = 3'b010;
  localparam logic [2:0] F_PERR  = 3'b001;

  logic       clk = 1'b0;
  logic       I_rst;
  logic       I_rx;
  logic [7:0] o_read_data;
  logic       o_read_data_valid, o_frame_error, o_parity_error;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  uart_rx_byte dut (
    .I_sys_clk         (clk),
    .I_rst             (I_rst),
    .I_rx              (I_rx),
    .o_read_data       (o_read_data),
    .o_read_data_valid (o_read_data_valid),
    .o_frame_error     (o_frame_error),
    .o_parity_error    (o_parity_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic expect_ev(input logic [2:0] flags, input logic [7:0] data);
    exp_t e;
    e.flags = flags;
    e.data  = data;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    I_rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_b);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par_b);
    send_bit(1'b1);
  endtask
`endif

  // Monitor: every strobe cycle must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    logic [2:0] seen;
    seen = {o_read_data_valid, o_frame_error, o_parity_error};
    if (seen != 3'b000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {29'd0, seen}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", {29'd0, seen}, {29'd0, e.flags});
        check("read_data", {24'd0, o_read_data}, {24'd0, e.data});
      end
    end
  end

  initial begin
    I_rst = 1'b1;
    I_rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", {24'd0, o_read_data}, 32'h00);
    check("reset_strobes", {29'd0, o_read_data_valid, o_frame_error, o_parity_error}, 32'd0);
    I_rst = 1'b0;
    send_bit(1'b1);

    // single byte
    expect_ev(F_VALID, 8'h61);
    send_frame(8'h61, 1'b1);

    // back-to-back, no idle gap
    expect_ev(F_VALID, 8'h77);
    expect_ev(F_VALID, 8'h73);
    expect_ev(F_VALID, 8'h6D);
    send_frame(8'h77, 1'b1);
    send_frame(8'h73, 1'b1);
    send_frame(8'h6D, 1'b1);

    // 3-tick glitch is rejected, following frame still received
    I_rx = 1'b0;
    repeat (3 * TICK_CLKS) @(negedge clk);
    send_bit(1'b1);
    expect_ev(F_VALID, 8'h64);
    send_frame(8'h64, 1'b1);

    // stop bit low then break: one frame error, data held at 64
    expect_ev(F_FERR, 8'h64);
    send_frame(8'h62, 1'b0);
    repeat (5) send_bit(1'b0);
    send_bit(1'b1);
    check("data_held_after_ferr", {24'd0, o_read_data}, 32'h64);
    expect_ev(F_VALID, 8'h6E);
    send_frame(8'h6E, 1'b1);

    // reset pulse during bit 4 aborts the frame
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1 & (i == 0));
    I_rx = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    I_rst = 1'b1;
    I_rx  = 1'b1;
    @(negedge clk);
    check("midreset_data", {24'd0, o_read_data}, 32'h00);
    check("midreset_strobes", {29'd0, o_read_data_valid, o_frame_error, o_parity_error}, 32'd0);
    I_rst = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    expect_ev(F_VALID, 8'h61);
    send_frame(8'h61, 1'b1);

`ifdef UART_RX_PARITY_EN
    expect_ev(F_VALID, 8'h61);
    send_frame_par(8'h61, 1'b1);
    expect_ev(F_PERR, 8'h61);
    send_frame_par(8'h61, 1'b0);
`endif

    for (int n = 0; n < 4 * BIT_CLKS && exp_q.size() != 0; n++) @(negedge clk);
    check("pending_expected", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
